// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: frame tick / sampling-start generator plus the
// credit tracker and packet launcher between the frame assembler and
// the LPC packet transmitter.
// Optional feature macro: WATCHDOG_EN (packet-completion watchdog).
module frame_tx_scheduler #(
  parameter int FRAME_DIV    = 50000,
  parameter int START_FRAMES = 16,
  parameter int DEPTH        = 8,
  parameter int PKT_TIMEOUT  = 200000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic       msec,
  output logic       timer,
  input  logic       frame_rdy,
  input  logic       packet_sent,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [3:0] rd_slot,
  output logic [3:0] occupancy,
  output logic       overflow,
  output logic       underflow,
  output logic       timeout
);

  localparam int DW = $clog2(FRAME_DIV);
  localparam int TW = $clog2(START_FRAMES + 1);

  localparam logic [DW-1:0] DIV_LAST   = DW'(FRAME_DIV - 1);
  localparam logic [TW-1:0] TICK_END   = TW'(START_FRAMES);
  localparam logic [TW-1:0] TICK_PRE   = TW'(START_FRAMES - 1);
  localparam logic [3:0]    OCC_FULL   = 4'(DEPTH);
  localparam logic [3:0]    SLOT_LAST  = 4'(DEPTH - 1);

  // One-hot state encoding
  localparam logic [4:0] IDLE      = 5'b00001;
  localparam logic [4:0] ARMED     = 5'b00010;
  localparam logic [4:0] READY     = 5'b00100;
  localparam logic [4:0] LAUNCH    = 5'b01000;
  localparam logic [4:0] WAIT_DONE = 5'b10000;

  logic [4:0]    state;
  logic [DW-1:0] div_cnt;
  logic [TW-1:0] tick_cnt;
  logic          inc;
  logic          dec;
  logic          wd_fire;

  // Frames only count once sampling has started; the watchdog retires a
  // stuck packet exactly as a packet_sent would.
  assign inc      = frame_rdy & timer;
  assign dec      = packet_sent | wd_fire;
  assign tx_start = (state == LAUNCH);

  // Frame tick divider: one-cycle msec pulse on each wrap to 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      msec    <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      msec    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      msec    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      msec    <= 1'b0;
    end
  end

  // Start delay: count ticks up to START_FRAMES, raise timer after the last one
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      timer    <= 1'b0;
    end else if (!enable) begin
      tick_cnt <= '0;
      timer    <= 1'b0;
    end else if (msec && tick_cnt != TICK_END) begin
      tick_cnt <= tick_cnt + 1'b1;
      if (tick_cnt == TICK_PRE) timer <= 1'b1;
    end
  end

  // Credit counter with sticky overflow/underflow; simultaneous +/- cancel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!enable) begin
      occupancy <= '0;
    end else if (inc && !dec) begin
      if (occupancy == OCC_FULL) overflow <= 1'b1;
      else                       occupancy <= occupancy + 4'd1;
    end else if (dec && !inc) begin
      if (occupancy == 4'd0) underflow <= 1'b1;
      else                   occupancy <= occupancy - 4'd1;
    end
  end

  // Launch sequencer: one packet in flight, slot pointer advances on completion
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rd_slot <= '0;
    end else if (!enable) begin
      state   <= IDLE;
      rd_slot <= '0;
    end else begin
      case (state)
        IDLE:      state <= ARMED;
        ARMED:     if (timer) state <= READY;
        READY:     if (occupancy != 4'd0 && !tx_busy) state <= LAUNCH;
        LAUNCH:    state <= WAIT_DONE;
        WAIT_DONE: if (packet_sent || wd_fire) begin
          state   <= READY;
          rd_slot <= (rd_slot == SLOT_LAST) ? 4'd0 : rd_slot + 4'd1;
        end
        default:   state <= IDLE;
      endcase
    end
  end

`ifdef WATCHDOG_EN
  localparam int WW = $clog2(PKT_TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(PKT_TIMEOUT - 1);

  logic [WW-1:0] wd_cnt;
  logic          timeout_q;

  assign wd_fire = enable && (state == WAIT_DONE) && (wd_cnt == WD_LAST) && !packet_sent;
  assign timeout = timeout_q;

  // Watchdog: count cycles spent waiting for packet_sent, flag on expiry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == WAIT_DONE && !packet_sent && !wd_fire) wd_cnt <= wd_cnt + 1'b1;
      else                                                 wd_cnt <= '0;
      if (wd_fire) timeout_q <= 1'b1;
    end
  end
`else
  // No watchdog: WAIT_DONE waits forever. PKT_TIMEOUT is referenced only so
  // the parameter stays part of the interface; the expression is constant 0.
  assign wd_fire = 1'b0;
  assign timeout = (PKT_TIMEOUT < 1);
`endif

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Self-checking bench for frame_tx_scheduler (FRAME_DIV=10, START_FRAMES=2,
// DEPTH=4, PKT_TIMEOUT=50). Launched slot indices are checked against a
// scoreboard queue filled when frames are accepted.
module tb_frame_tx_scheduler;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       frame_rdy = 1'b0;
  logic       packet_sent = 1'b0;
  logic       tx_busy = 1'b0;
  logic       msec, timer, tx_start, overflow, underflow, timeout;
  logic [3:0] rd_slot, occupancy;

  int total = 0;
  int bad = 0;
  int launches = 0;
  int exp_q[$];
  int wr_slot = 0;
  int m_occ = 0;

  frame_tx_scheduler #(
    .FRAME_DIV(10), .START_FRAMES(2), .DEPTH(DEPTH), .PKT_TIMEOUT(50)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .msec(msec), .timer(timer),
    .frame_rdy(frame_rdy), .packet_sent(packet_sent), .tx_busy(tx_busy),
    .tx_start(tx_start), .rd_slot(rd_slot), .occupancy(occupancy),
    .overflow(overflow), .underflow(underflow), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Scoreboard: every launch must match the next accepted frame's slot
  always @(negedge clock) begin
    if (!reset && tx_start) begin
      launches++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL launch_unexpected rd_slot=%0d queue empty", rd_slot);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (rd_slot !== 4'(e)) begin
          bad++;
          $display("FAIL launch_slot got=%0d exp=%0d", rd_slot, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One-cycle frame_rdy pulse, updating the credit/slot model
  task automatic pulse_frame();
    frame_rdy = 1'b1;
    if (m_occ < DEPTH) begin
      exp_q.push_back(wr_slot);
      wr_slot = (wr_slot + 1) % DEPTH;
      m_occ++;
    end
    step();
    frame_rdy = 1'b0;
  endtask

  task automatic wait_launch(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (tx_start === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s no tx_start within 20 cycles", name);
    end
  endtask

  // Called in the tx_start cycle: complete the packet one cycle later
  task automatic finish_packet();
    step();
    total++;
    if (tx_start !== 1'b0) begin
      bad++;
      $display("FAIL tx_start_repeat got=%b exp=0", tx_start);
    end
    packet_sent = 1'b1;
    step();
    packet_sent = 1'b0;
    m_occ--;
  endtask

  task automatic chk_occ(input string name);
    total++;
    if (occupancy !== 4'(m_occ)) begin
      bad++;
      $display("FAIL %s occupancy got=%0d exp=%0d", name, occupancy, m_occ);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++;
    if ({msec, timer, tx_start, rd_slot, occupancy, overflow, underflow, timeout} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0",
               {msec, timer, tx_start, rd_slot, occupancy, overflow, underflow, timeout});
    end
    reset = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_startup();
    for (int c = 1; c <= 35; c++) begin
      step();
      total++;
      if (msec !== (c % 10 == 0) || timer !== (c >= 21) || tx_start !== 1'b0) begin
        bad++;
        $display("FAIL startup cycle=%0d msec=%b timer=%b tx_start=%b exp msec=%b timer=%b",
                 c, msec, timer, tx_start, (c % 10 == 0), (c >= 21));
      end
    end
  endtask

  task automatic test_single();
    pulse_frame();
    chk_occ("single_occ");
    total++;
    if (tx_start !== 1'b0) begin
      bad++;
      $display("FAIL single_early tx_start=%b exp=0", tx_start);
    end
    step();
    total++;
    if (tx_start !== 1'b1) begin
      bad++;
      $display("FAIL single_latency tx_start=%b exp=1", tx_start);
    end
    finish_packet();
    chk_occ("single_done_occ");
    pulse_frame();
    wait_launch("single_second");
    finish_packet();
    chk_occ("single_second_occ");
  endtask

  task automatic test_busy_hold();
    int l0;
    tx_busy = 1'b1;
    l0 = launches;
    for (int i = 0; i < 3; i++) begin
      pulse_frame();
      step();
    end
    chk_occ("busy_occ");
    total++;
    if (launches != l0) begin
      bad++;
      $display("FAIL busy_no_launch got=%0d exp=0", launches - l0);
    end
    tx_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_launch("busy_drain");
      finish_packet();
    end
    repeat (3) step();
    chk_occ("busy_drained_occ");
    total++;
    if (launches - l0 != 3) begin
      bad++;
      $display("FAIL busy_launch_count got=%0d exp=3", launches - l0);
    end
  endtask

  task automatic test_full();
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse_frame();
      step();
    end
    chk_occ("full_occ");
    total++;
    if (overflow !== 1'b1 || underflow !== 1'b0) begin
      bad++;
      $display("FAIL full_flags overflow=%b underflow=%b exp 1 0", overflow, underflow);
    end
    // Frame arriving together with a completion at full: net zero
    frame_rdy = 1'b1;
    packet_sent = 1'b1;
    step();
    frame_rdy = 1'b0;
    packet_sent = 1'b0;
    chk_occ("simul_occ");
    total++;
    if (underflow !== 1'b0) begin
      bad++;
      $display("FAIL simul_underflow got=%b exp=0", underflow);
    end
    tx_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_launch("full_drain");
      finish_packet();
    end
    repeat (2) step();
    chk_occ("full_drained_occ");
  endtask

  task automatic test_underflow_abort();
    packet_sent = 1'b1;
    step();
    packet_sent = 1'b0;
    chk_occ("under_occ");
    total++;
    if (underflow !== 1'b1) begin
      bad++;
      $display("FAIL underflow_flag got=%b exp=1", underflow);
    end
    pulse_frame();
    wait_launch("abort_launch");
    step();                                  // now in WAIT_DONE
    enable = 1'b0;
    step();
    exp_q.delete();
    wr_slot = 0;
    m_occ = 0;
    chk_occ("abort_occ");
    total++;
    if (timer !== 1'b0 || underflow !== 1'b1 || overflow !== 1'b1 || rd_slot !== 4'd0) begin
      bad++;
      $display("FAIL abort_state timer=%b underflow=%b overflow=%b rd_slot=%0d exp 0 1 1 0",
               timer, underflow, overflow, rd_slot);
    end
    // Re-enable: frames before timer are ignored, slot pointer restarts at 0
    enable = 1'b1;
    step();
    frame_rdy = 1'b1;
    step();
    frame_rdy = 1'b0;
    step();
    chk_occ("pre_timer_ignored");
    begin
      bit up;
      up = 1'b0;
      for (int i = 0; i < 40 && !up; i++) begin
        step();
        if (timer === 1'b1) up = 1'b1;
      end
      total++;
      if (!up) begin
        bad++;
        $display("FAIL restart_timer no timer within 40 cycles");
      end
    end
    pulse_frame();
    wait_launch("restart_launch");
    finish_packet();
  endtask

  task automatic test_watchdog();
`ifdef WATCHDOG_EN
    bit hit;
    pulse_frame();
    wait_launch("wd_launch");
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      if (timeout === 1'b1) hit = 1'b1;
    end
    m_occ--;
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL watchdog_timeout not set within 60 cycles");
    end
    step();
    chk_occ("wd_occ");
    pulse_frame();
    wait_launch("wd_next_launch");
    finish_packet();
`else
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_tied got=%b exp=0", timeout);
    end
`endif
  endtask

  task automatic test_mid_reset();
    tx_busy = 1'b1;
    pulse_frame();
    pulse_frame();
    chk_occ("pre_reset_occ");
    reset = 1'b1;
    #1;
    exp_q.delete();
    wr_slot = 0;
    m_occ = 0;
    total++;
    if ({msec, timer, tx_start, rd_slot, occupancy, overflow, underflow, timeout} !== 14'd0) begin
      bad++;
      $display("FAIL mid_reset got=%b exp=0",
               {msec, timer, tx_start, rd_slot, occupancy, overflow, underflow, timeout});
    end
    tx_busy = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (tx_start !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_tx_start cycle=%0d got=%b exp=0", i, tx_start);
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_single();
    test_busy_hold();
    test_full();
    test_underflow_abort();
    test_watchdog();
    test_mid_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
